// File: rtl/pulse_trigger_peak.sv
// Two-stage pulse trigger: stage 1 reduces each valid block to hot/max/lane, stage 2 tracks pulses.
// Defining PULSE_AREA_EN adds pulse_area, the saturated signed sum of above-threshold samples.
module pulse_trigger_peak #(
    parameter int DATA_OUTPUT = 17,
    parameter int LANES       = 16,
    parameter int TS_WIDTH    = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                din_valid,
    input  logic [DATA_OUTPUT*LANES-1:0]        din,
    input  logic signed [DATA_OUTPUT-1:0]       threshold,
    input  logic [15:0]                         holdoff,
    output logic                                pulse_valid,
    output logic signed [DATA_OUTPUT-1:0]       pulse_peak,
    output logic [TS_WIDTH-1:0]                 pulse_ts,
    output logic [15:0]                         pulse_width,
`ifdef PULSE_AREA_EN
    output logic signed [31:0]                  pulse_area,
`endif
    output logic [1:0]                          fsm_state_o
);
    // Handshake: din_valid qualifies din for one cycle; there is no backpressure and
    // pulse_valid is a single-cycle strobe with the record held until the next one.
    localparam int LW   = $clog2(LANES);
    localparam int BW   = TS_WIDTH - LW;
    localparam int SUMW = DATA_OUTPUT + LW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, HOLDOFF = 2'd2} state_t;

    logic signed [DATA_OUTPUT-1:0] lane_s [LANES];
    logic                          hot_d;
    logic signed [DATA_OUTPUT-1:0] max_d;
    logic [LW-1:0]                 lane_d;

    logic [BW-1:0]                 blk_cnt_q;
    logic                          s1_valid_q;
    logic                          s1_hot_q;
    logic signed [DATA_OUTPUT-1:0] s1_max_q;
    logic [LW-1:0]                 s1_lane_q;
    logic [BW-1:0]                 s1_blk_q;

    state_t                        state_q;
    logic [15:0]                   hold_cnt_q;
    logic signed [DATA_OUTPUT-1:0] cur_peak_q;
    logic [TS_WIDTH-1:0]           cur_ts_q;
    logic [15:0]                   cur_width_q;
    logic                          pulse_valid_q;
    logic signed [DATA_OUTPUT-1:0] peak_q;
    logic [TS_WIDTH-1:0]           ts_q;
    logic [15:0]                   width_q;
    logic [TS_WIDTH-1:0]           s1_ts;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_s[i] = $signed(din[i*DATA_OUTPUT +: DATA_OUTPUT]);
        end
    end

    // Strict > keeps the earliest lane when several lanes share the block maximum.
    always_comb begin
        hot_d  = 1'b0;
        max_d  = lane_s[0];
        lane_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_s[i] > threshold) hot_d = 1'b1;
            if (lane_s[i] > max_d) begin
                max_d  = lane_s[i];
                lane_d = LW'(i);
            end
        end
    end

`ifdef PULSE_AREA_EN
    logic signed [SUMW-1:0] sum_d;
    logic signed [SUMW-1:0] s1_sum_q;
    logic signed [31:0]     cur_area_q;
    logic signed [31:0]     area_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_s[i] > threshold) sum_d = sum_d + SUMW'(lane_s[i]);
        end
    end

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [SUMW-1:0] b);
        logic signed [32:0] s;
        s = {a[31], a} + {{(33-SUMW){b[SUMW-1]}}, b};
        if (s[32] != s[31]) return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        return s[31:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum_q <= '0;
        end else if (din_valid) begin
            s1_sum_q <= sum_d;
        end
    end

    assign pulse_area = area_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_hot_q   <= 1'b0;
            s1_max_q   <= '0;
            s1_lane_q  <= '0;
            s1_blk_q   <= '0;
        end else begin
            s1_valid_q <= din_valid;
            if (din_valid) begin
                s1_hot_q  <= hot_d;
                s1_max_q  <= max_d;
                s1_lane_q <= lane_d;
                s1_blk_q  <= blk_cnt_q;
                blk_cnt_q <= blk_cnt_q + BW'(1);
            end
        end
    end

    assign s1_ts = {s1_blk_q, s1_lane_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            cur_peak_q    <= '0;
            cur_ts_q      <= '0;
            cur_width_q   <= '0;
            pulse_valid_q <= 1'b0;
            peak_q        <= '0;
            ts_q          <= '0;
            width_q       <= '0;
`ifdef PULSE_AREA_EN
            cur_area_q    <= '0;
            area_q        <= '0;
`endif
        end else begin
            pulse_valid_q <= 1'b0;
            if (s1_valid_q) begin
                case (state_q)
                    IDLE: begin
                        if (s1_hot_q) begin
                            state_q     <= PULSE;
                            cur_peak_q  <= s1_max_q;
                            cur_ts_q    <= s1_ts;
                            cur_width_q <= 16'd1;
`ifdef PULSE_AREA_EN
                            cur_area_q  <= sat_add(32'sd0, s1_sum_q);
`endif
                        end
                    end
                    PULSE: begin
                        if (s1_hot_q) begin
                            if (cur_width_q != 16'hFFFF) cur_width_q <= cur_width_q + 16'd1;
                            if (s1_max_q > cur_peak_q) begin
                                cur_peak_q <= s1_max_q;
                                cur_ts_q   <= s1_ts;
                            end
`ifdef PULSE_AREA_EN
                            cur_area_q <= sat_add(cur_area_q, s1_sum_q);
`endif
                        end else begin
                            pulse_valid_q <= 1'b1;
                            peak_q        <= cur_peak_q;
                            ts_q          <= cur_ts_q;
                            width_q       <= cur_width_q;
`ifdef PULSE_AREA_EN
                            area_q        <= cur_area_q;
`endif
                            hold_cnt_q    <= holdoff;
                            state_q       <= (holdoff == 16'd0) ? IDLE : HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        hold_cnt_q <= hold_cnt_q - 16'd1;
                        if (hold_cnt_q == 16'd1) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pulse_valid = pulse_valid_q;
    assign pulse_peak  = peak_q;
    assign pulse_ts    = ts_q;
    assign pulse_width = width_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_pulse_trigger_peak.sv
// Bench for pulse_trigger_peak: reset, vector table, directed corner sequences, random vs. reference model.
`timescale 1ns/1ps
module tb_pulse_trigger_peak;
  localparam int DW  = 17;
  localparam int L   = 16;
  localparam int TSW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 din_valid = 1'b0;
  logic [DW*L-1:0]      din = '0;
  logic signed [DW-1:0] threshold = '0;
  logic [15:0]          holdoff = '0;
  logic                 pulse_valid;
  logic signed [DW-1:0] pulse_peak;
  logic [TSW-1:0]       pulse_ts;
  logic [15:0]          pulse_width;
  logic [1:0]           fsm_state_o;
`ifdef PULSE_AREA_EN
  logic signed [31:0]   pulse_area;
`endif

  pulse_trigger_peak #(.DATA_OUTPUT(DW), .LANES(L), .TS_WIDTH(TSW)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .threshold(threshold), .holdoff(holdoff),
    .pulse_valid(pulse_valid), .pulse_peak(pulse_peak), .pulse_ts(pulse_ts),
    .pulse_width(pulse_width),
`ifdef PULSE_AREA_EN
    .pulse_area(pulse_area),
`endif
    .fsm_state_o(fsm_state_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int      peak;
    longint  ts;
    int      width;
    int      cyc;
  } rec_t;

  rec_t                 act_q[$];
  logic [DW*L-1:0]      blk_q[$];
  logic signed [DW-1:0] bthr_q[$];
  int                   bcyc_q[$];
  int                   cur_holdoff = 0;
  int                   checks = 0;
  int                   errors = 0;

  always @(negedge clk) begin
    if (rst_n && pulse_valid)
      act_q.push_back('{int'(pulse_peak), longint'(pulse_ts), int'(pulse_width), cyc});
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // driver tasks
  function automatic logic [DW*L-1:0] mk(input int bg, input int l1, input int v1,
                                         input int l2, input int v2);
    logic [DW*L-1:0] b;
    for (int i = 0; i < L; i++) b[i*DW +: DW] = DW'(bg);
    if (l1 >= 0) b[l1*DW +: DW] = DW'(v1);
    if (l2 >= 0) b[l2*DW +: DW] = DW'(v2);
    return b;
  endfunction

  function automatic logic [DW*L-1:0] rnd_blk(input bit quiet);
    logic [DW*L-1:0] b;
    int v;
    for (int i = 0; i < L; i++) begin
      v = quiet ? int'($urandom_range(0, 4)) * 25 - 100 : int'($urandom_range(0, 8)) * 25 - 100;
      b[i*DW +: DW] = DW'(v);
    end
    return b;
  endfunction

  task automatic drive(input logic [DW*L-1:0] d, input logic v, input int thr);
    @(posedge clk); #1;
    din = d;
    din_valid = v;
    threshold = DW'(thr);
    if (v) begin
      blk_q.push_back(d);
      bthr_q.push_back(DW'(thr));
      bcyc_q.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, 1'b0, 0);
  endtask

  task automatic do_reset(input int ho);
    @(posedge clk); #1;
    rst_n = 1'b0;
    din_valid = 1'b0;
    holdoff = 16'(ho);
    cur_holdoff = ho;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    blk_q.delete(); bthr_q.delete(); bcyc_q.delete(); act_q.delete();
  endtask

  task automatic check_rec(input string nm, input int peak, input longint ts,
                           input int width, input int ecyc);
    rec_t r;
    checks++;
    if (act_q.size() == 0) begin
      errors++;
      $display("FAIL %s.present actual=0 records required=1", nm);
      return;
    end
    checks--;
    r = act_q.pop_front();
    chk({nm, ".peak"}, r.peak, peak);
    chk({nm, ".ts"}, r.ts, ts);
    chk({nm, ".width"}, r.width, width);
    chk({nm, ".cycle"}, r.cyc, ecyc);
  endtask

  task automatic check_none(input string nm);
    chk({nm, ".extra_records"}, act_q.size(), 0);
  endtask

  // reference model: scan the stored valid blocks for pulses
  function automatic int lane_of(input logic [DW*L-1:0] d, input int l);
    logic signed [DW-1:0] s;
    s = d[l*DW +: DW];
    return int'(s);
  endfunction

  function automatic bit is_hot(input int i);
    for (int l = 0; l < L; l++)
      if (lane_of(blk_q[i], l) > int'(bthr_q[i])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_check(input int s);
    rec_t exp_q[$];
    int   i, j, n, pk, m;
    longint ts;
    i = 0;
    n = blk_q.size();
    while (i < n) begin
      if (is_hot(i)) begin
        j  = i;
        pk = -(1 << 20);
        ts = 0;
        while (j < n && is_hot(j)) begin
          for (int l = 0; l < L; l++)
            if (lane_of(blk_q[j], l) > pk) begin
              pk = lane_of(blk_q[j], l);
              ts = longint'(j) * L + l;
            end
          j++;
        end
        if (j < n) begin
          exp_q.push_back('{pk, ts, (j - i > 65535) ? 65535 : j - i, bcyc_q[j] + 2});
          i = j + 1 + cur_holdoff;
        end else begin
          i = n;
        end
      end else begin
        i++;
      end
    end
    chk($sformatf("rand%0d.count", s), act_q.size(), exp_q.size());
    m = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      chk($sformatf("rand%0d.rec%0d.peak", s, k), act_q[k].peak, exp_q[k].peak);
      chk($sformatf("rand%0d.rec%0d.ts", s, k), act_q[k].ts, exp_q[k].ts);
      chk($sformatf("rand%0d.rec%0d.width", s, k), act_q[k].width, exp_q[k].width);
      chk($sformatf("rand%0d.rec%0d.cycle", s, k), act_q[k].cyc, exp_q[k].cyc);
    end
  endtask

  typedef struct {
    int pre; int bg; int lane; int val; int thr;
    bit exp_v; int exp_peak; int exp_ts;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   n, n2, thr;
    logic [DW*L-1:0] b;

    vecs[0] = '{3,   0,  5,   300, 100, 1'b1,   300, 53};
    vecs[1] = '{0,   0,  0,   101, 100, 1'b1,   101,  0};
    vecs[2] = '{2,   0, 15, 65535,   0, 1'b1, 65535, 47};
    vecs[3] = '{1,   0,  3,   100, 100, 1'b0,     0,  0};
    vecs[4] = '{1, -20,  2,    -3, -10, 1'b1,    -3, 18};
    vecs[5] = '{4,   0,  8,     1,   0, 1'b1,     1, 72};

    // reset held with random valid data
    rst_n = 1'b0;
    threshold = 17'sd100;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      din = rnd_blk(1'b0);
      din_valid = 1'b1;
      @(negedge clk);
      chk("reset.pulse_valid", pulse_valid, 0);
      chk("reset.peak", pulse_peak, 0);
      chk("reset.ts", pulse_ts, 0);
      chk("reset.width", pulse_width, 0);
      chk("reset.state", fsm_state_o, 0);
    end

    // table of single-block pulses
    foreach (vecs[k]) begin
      do_reset(0);
      for (int p = 0; p < vecs[k].pre; p++) drive(mk(vecs[k].bg, -1, 0, -1, 0), 1'b1, vecs[k].thr);
      drive(mk(vecs[k].bg, vecs[k].lane, vecs[k].val, -1, 0), 1'b1, vecs[k].thr);
      drive(mk(vecs[k].bg, -1, 0, -1, 0), 1'b1, vecs[k].thr);
      n = cyc;
      idle(4);
      if (vecs[k].exp_v) begin
        check_rec($sformatf("vec%0d", k), vecs[k].exp_peak, vecs[k].exp_ts, 1, n + 2);
        chk($sformatf("vec%0d.hold_peak", k), pulse_peak, vecs[k].exp_peak);
      end
      check_none($sformatf("vec%0d", k));
    end

    // multi-block pulse with tied peaks: the earliest 800 wins
    do_reset(0);
    drive(mk(0, 3, 200, -1, 0), 1'b1, 100);
    drive(mk(0, 7, 800, 9, 800), 1'b1, 100);
    drive(mk(0, 0, 800, -1, 0), 1'b1, 100);
    drive('0, 1'b1, 100);
    n = cyc;
    idle(4);
    check_rec("tie", 800, 23, 3, n + 2);
    chk("tie.hold_width", pulse_width, 3);
    check_none("tie");

    // holdoff=4 ignores four blocks, the fifth starts a new pulse
    do_reset(4);
    drive(mk(0, 1, 200, -1, 0), 1'b1, 100);
    drive('0, 1'b1, 100);
    n = cyc;
    repeat (3) drive(mk(0, 0, 900, -1, 0), 1'b1, 100);
    drive('0, 1'b1, 100);
    drive(mk(0, 4, 300, -1, 0), 1'b1, 100);
    drive('0, 1'b1, 100);
    n2 = cyc;
    idle(4);
    check_rec("holdoff.first", 200, 1, 1, n + 2);
    check_rec("holdoff.second", 300, 100, 1, n2 + 2);
    check_none("holdoff");

    // hot data on invalid cycles is ignored and does not advance the block index
    do_reset(0);
    drive('0, 1'b1, 100);
    repeat (3) drive(mk(500, -1, 0, -1, 0), 1'b0, 100);
    drive('0, 1'b1, 100);
    drive(mk(500, -1, 0, -1, 0), 1'b0, 100);
    drive('0, 1'b1, 100);
    drive(mk(0, 2, 200, -1, 0), 1'b1, 100);
    drive('0, 1'b1, 100);
    n = cyc;
    idle(4);
    check_rec("invalid", 200, 50, 1, n + 2);
    check_none("invalid");

    // reset in the middle of a pulse discards it and restarts block indexing
    do_reset(0);
    drive(mk(0, 1, 400, -1, 0), 1'b1, 100);
    drive(mk(0, 2, 500, -1, 0), 1'b1, 100);
    check_none("midreset.before");
    do_reset(0);
    drive('0, 1'b1, 100);
    drive(mk(0, 6, 150, -1, 0), 1'b1, 100);
    drive('0, 1'b1, 100);
    n = cyc;
    idle(4);
    check_rec("midreset", 150, 22, 1, n + 2);
    check_none("midreset");

`ifdef PULSE_AREA_EN
    do_reset(0);
    b = '0;
    for (int l = 0; l < 4; l++) b[l*DW +: DW] = DW'(200);
    b[4*DW +: DW] = DW'(100);
    drive(b, 1'b1, 100);
    drive('0, 1'b1, 100);
    n = cyc;
    idle(4);
    check_rec("area", 200, 0, 1, n + 2);
    chk("area.sum", pulse_area, 800);
`endif

    // randomized scenarios against the block-scanning model
    for (int s = 0; s < 8; s++) begin
      do_reset($urandom_range(0, 3));
      thr = int'($urandom_range(0, 3)) * 25;
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 3) == 0) drive(rnd_blk(1'b0), 1'b0, thr);
        else drive(rnd_blk(1'($urandom_range(0, 1))), 1'b1, thr);
      end
      idle(4);
      model_check(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
